xalu_ise_pipe: RTL and testbench

//  Parametrised successor to the CSIDH full-radix custom-0 ALU extension. Sits beside the core ALU.

---
 rtl/csidh_ise_pkg.sv | 25 ++
 rtl/xalu_ise_mul.sv | 80 ++++++++
 rtl/xalu_ise_pipe.sv | 115 +++++++++++
 tb/tb_xalu_ise_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/csidh_ise_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csidh_ise_pkg : shared op-codes, major-opcode encodings and FSM states.
// Rev 1.0
// ---------------------------------------------------------------------------
package csidh_ise_pkg;

  localparam logic [3:0] OP_ANDADD = 4'b0111;
  localparam logic [3:0] OP_SUB    = 4'b0011;
  localparam logic [3:0] OP_MULLO  = 4'b1011;
  localparam logic [3:0] OP_MULHI  = 4'b1111;

  localparam logic [1:0] CUSTOM_0 = 2'b00;
  localparam logic [1:0] CUSTOM_1 = 2'b01;
  localparam logic [1:0] CUSTOM_2 = 2'b10;
  localparam logic [1:0] CUSTOM_3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/xalu_ise_mul.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xalu_ise_mul : digit-serial XLEN x XLEN multiplier, DIGIT bits of rs2 per cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
module xalu_ise_mul
  import csidh_ise_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DIGIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            run,
  input  logic            kill,
  input  logic            hi_sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            last,
  output logic [XLEN-1:0] res
);

  localparam int N     = XLEN / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int W2    = 2 * XLEN;

  logic [W2-1:0]    a_q, a_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hi_q, hi_d;
  logic [W2-1:0]    part;

  assign last = (cnt_q == CNT_W'(N - 1));
  assign res  = hi_q ? acc_q[W2-1:XLEN] : acc_q[XLEN-1:0];

  // rs1 is pre-shifted by DIGIT every step so the partial product lands at cnt*DIGIT.
  always_comb begin
    part  = a_q * W2'(b_q[DIGIT-1:0]);
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    if (start) begin
      a_d   = W2'(a);
      b_d   = b;
      acc_d = '0;
      cnt_d = '0;
      hi_d  = hi_sel;
    end else if (kill) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (run) begin
      acc_d = acc_q + part;
      a_d   = a_q << DIGIT;
      b_d   = b_q >> DIGIT;
      if (!last) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      hi_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xalu_ise_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// xalu_ise_pipe : custom-0 ALU extension with single-cycle ANDADD/SUB and serial MULLO/MULHI.
// Rev 1.0
// ---------------------------------------------------------------------------
module xalu_ise_pipe
  import csidh_ise_pkg::*;
#(
  parameter int         XLEN  = 64,
  parameter int         DIGIT = 16,
  parameter logic [1:0] ISE_V = 2'b11
) (
  input  logic            ise_clk,
  input  logic            ise_rst,
  input  logic [5:0]      ise_fn,
  input  logic [6:0]      ise_imm,
  input  logic [XLEN-1:0] ise_in1,
  input  logic [XLEN-1:0] ise_in2,
  input  logic            ise_val,
  input  logic            ise_kill,
  output logic            ise_rdy,
  output logic            ise_oval,
  output logic [XLEN-1:0] ise_out
);

  generate
    if ((DIGIT <= 0) || (XLEN % DIGIT != 0)) begin : g_bad_digit
      $error("xalu_ise_pipe: XLEN must be a multiple of DIGIT");
    end
  endgenerate

  state_e          state_q, state_d;
  logic            alu_val_q, alu_val_d;
  logic [XLEN-1:0] alu_res_q, alu_res_d;
  logic            mul_start, mul_run, mul_kill, mul_last;
  logic [XLEN-1:0] mul_res;
  logic            accept, is_custom0, is_alu, is_mul;
  logic [3:0]      op;
  logic [XLEN-1:0] alu_calc;
  logic            unused_bits;

  assign unused_bits = ^{ise_fn[5:2], ise_imm[6:5]};

  assign op         = ise_imm[3:0];
  assign is_custom0 = (ise_fn[1:0] == CUSTOM_0);
  assign is_alu     = is_custom0 & ISE_V[1] & ((op == OP_ANDADD) | (op == OP_SUB));
  assign is_mul     = is_custom0 & ISE_V[0] & ((op == OP_MULLO) | (op == OP_MULHI));
  assign alu_calc   = (op == OP_ANDADD) ? ise_in1 + (ise_in2 & {XLEN{ise_imm[4]}})
                                        : ise_in1 - ise_in2 - XLEN'(ise_imm[4]);

  assign ise_rdy = (state_q == ST_IDLE) & ~ise_rst;
  assign accept  = ise_val & ise_rdy;
  assign mul_run = (state_q == ST_MUL);
  assign mul_kill = ise_kill & mul_run;

  // Unsupported requests are accepted but leave both result paths idle.
  always_comb begin
    state_d   = state_q;
    alu_val_d = 1'b0;
    alu_res_d = '0;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_alu) begin
          alu_val_d = 1'b1;
          alu_res_d = alu_calc;
        end
        if (accept && is_mul) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        if (ise_kill)      state_d = ST_IDLE;
        else if (mul_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      state_q   <= ST_IDLE;
      alu_val_q <= 1'b0;
      alu_res_q <= '0;
    end else begin
      state_q   <= state_d;
      alu_val_q <= alu_val_d;
      alu_res_q <= alu_res_d;
    end
  end

  xalu_ise_mul #(
    .XLEN  (XLEN),
    .DIGIT (DIGIT)
  ) u_mul (
    .clk    (ise_clk),
    .rst    (ise_rst),
    .start  (mul_start),
    .run    (mul_run),
    .kill   (mul_kill),
    .hi_sel (op == OP_MULHI),
    .a      (ise_in1),
    .b      (ise_in2),
    .last   (mul_last),
    .res    (mul_res)
  );

  // Outputs are held at zero through reset, even if a strobe was pending.
  assign ise_oval = ~ise_rst & (alu_val_q | (state_q == ST_DONE));
  assign ise_out  = !ise_oval ? '0 : (alu_val_q ? alu_res_q : mul_res);

endmodule
`default_nettype wire

// File: tb/tb_xalu_ise_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_xalu_ise_pipe : directed stimulus, cycle-by-cycle model comparison plus literal pins.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_xalu_ise_pipe;

  localparam int XLEN = 64;
  localparam int N    = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, val, val2, kill;
  logic [5:0]  fn;
  logic [6:0]  imm;
  logic [63:0] in1, in2;
  logic        rdy, oval, rdy2, oval2;
  logic [63:0] out, out2;

  xalu_ise_pipe dut (
    .ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
    .ise_in1(in1), .ise_in2(in2), .ise_val(val), .ise_kill(kill),
    .ise_rdy(rdy), .ise_oval(oval), .ise_out(out)
  );

  xalu_ise_pipe #(.ISE_V(2'b10)) dut2 (
    .ise_clk(clk), .ise_rst(rst), .ise_fn(fn), .ise_imm(imm),
    .ise_in1(in1), .ise_in2(in2), .ise_val(val2), .ise_kill(kill),
    .ise_rdy(rdy2), .ise_oval(oval2), .ise_out(out2)
  );

  int checks = 0;
  int errors = 0;

  function automatic void lit(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endfunction

  // Reference: 0 = no result, 1 = ALU (next cycle), 2 = multiply (N+1 cycles later).
  function automatic int model_kind(logic [5:0] f, logic [6:0] im);
    if (f[1:0] != 2'b00) return 0;
    case (im[3:0])
      4'h7, 4'h3: return 1;
      4'hB, 4'hF: return 2;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] model_res(logic [6:0] im, logic [63:0] a, logic [63:0] b);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    case (im[3:0])
      4'h7:    return a + (im[4] ? b : 64'd0);
      4'h3:    return a - b - {63'd0, im[4]};
      4'hB:    return p[63:0];
      default: return p[127:64];
    endcase
  endfunction

  logic [63:0] exp_res [int];
  int          cyc = 0;
  int          busy_end = -1;
  int          mul_acc = 0;
  bit          mul_act = 1'b0;
  bit          started = 1'b0;
  logic        m_oval, m_rdy;
  logic [63:0] m_out;
  int          kind;

  always @(negedge clk) begin
    if (rst) begin
      started = 1'b1;
      exp_res.delete();
      busy_end = cyc;
      mul_act = 1'b0;
    end
    if (started) begin
      m_oval = !rst && exp_res.exists(cyc);
      m_out  = m_oval ? exp_res[cyc] : 64'd0;
      m_rdy  = !rst && (cyc > busy_end);
      lit($sformatf("oval@%0d", cyc), {63'd0, oval}, {63'd0, m_oval});
      lit($sformatf("out@%0d", cyc), out, m_out);
      lit($sformatf("rdy@%0d", cyc), {63'd0, rdy}, {63'd0, m_rdy});
      if (m_oval) exp_res.delete(cyc);
      if (!rst) begin
        if (kill && mul_act && cyc > mul_acc && cyc <= mul_acc + N) begin
          exp_res.delete(mul_acc + N + 1);
          busy_end = cyc;
          mul_act = 1'b0;
        end
        if (val && m_rdy) begin
          kind = model_kind(fn, imm);
          if (kind == 1) exp_res[cyc + 1] = model_res(imm, in1, in2);
          if (kind == 2) begin
            exp_res[cyc + N + 1] = model_res(imm, in1, in2);
            busy_end = cyc + N + 1;
            mul_acc = cyc;
            mul_act = 1'b1;
          end
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(logic [5:0] f, logic [6:0] im, logic [63:0] a, logic [63:0] b);
    fn = f; imm = im; in1 = a; in2 = b; val = 1'b1;
  endtask

  initial begin
    rst = 1'b1; val = 1'b0; val2 = 1'b0; kill = 1'b0;
    fn = '0; imm = '0; in1 = '0; in2 = '0;
    mid();
    lit("rst_rdy", {63'd0, rdy}, 64'd0);
    lit("rst_oval", {63'd0, oval}, 64'd0);
    lit("rst_out", out, 64'd0);
    tick();
    rst = 1'b0;
    mid();
    lit("post_rst_rdy", {63'd0, rdy}, 64'd1);
    tick();

    // ANDADD with and without the mask bit; reserved funct bits ignored
    drive(6'd0, 7'h17, ONES, 64'd1); tick(); val = 1'b0;
    mid(); lit("andadd_oval", {63'd0, oval}, 64'd1); lit("andadd_wrap", out, 64'd0); tick();
    mid(); lit("andadd_oval_1cyc", {63'd0, oval}, 64'd0); tick();
    drive(6'd0, 7'h07, ONES, 64'd1); tick(); val = 1'b0;
    mid(); lit("andadd_nomask", out, ONES); tick();
    drive(6'd0, 7'h67, 64'd5, 64'd9); tick(); val = 1'b0;
    mid(); lit("andadd_resv", out, 64'd5); tick();

    // SUB with borrow, then three back-to-back
    drive(6'd0, 7'h13, 64'd5, 64'd7); tick(); val = 1'b0;
    mid(); lit("sub_borrow", out, 64'hFFFF_FFFF_FFFF_FFFD); tick();
    drive(6'd0, 7'h03, 64'd10, 64'd3); tick();
    drive(6'd0, 7'h13, 64'd100, 64'd1); mid(); lit("b2b_1", out, 64'd7); tick();
    drive(6'd0, 7'h03, 64'd0, 64'd1); mid(); lit("b2b_2", out, 64'd98); tick();
    val = 1'b0; mid(); lit("b2b_3", out, ONES); tick();
    mid(); lit("b2b_end", {63'd0, oval}, 64'd0); tick();

    // MULHI / MULLO of all-ones operands
    drive(6'd0, 7'h0F, ONES, ONES); tick(); val = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      mid();
      lit($sformatf("mulhi_rdy_t%0d", i), {63'd0, rdy}, 64'd0);
      if (i < 5) lit($sformatf("mulhi_oval_t%0d", i), {63'd0, oval}, 64'd0);
      else begin
        lit("mulhi_oval", {63'd0, oval}, 64'd1);
        lit("mulhi_out", out, 64'hFFFF_FFFF_FFFF_FFFE);
      end
      tick();
    end
    mid(); lit("mulhi_rdy_back", {63'd0, rdy}, 64'd1); tick();
    drive(6'd0, 7'h0B, ONES, ONES); tick(); val = 1'b0;
    repeat (4) tick();
    mid(); lit("mullo_out", out, 64'd1); tick();

    // Request held while busy is only taken once ready returns
    drive(6'd0, 7'h0B, 64'd3, 64'd5);
    for (int i = 0; i <= 6; i++) begin
      if (i == 3) begin mid(); lit("hold_rdy_busy", {63'd0, rdy}, 64'd0); end
      if (i == 5) begin mid(); lit("hold_out", out, 64'd15); end
      if (i == 6) begin mid(); lit("hold_rdy_back", {63'd0, rdy}, 64'd1); end
      tick();
    end
    val = 1'b0;
    repeat (6) tick();

    // Kill during MUL
    drive(6'd0, 7'h0B, 64'd3, 64'd5); tick(); val = 1'b0; tick();
    kill = 1'b1; mid(); lit("kill_rdy_busy", {63'd0, rdy}, 64'd0); tick();
    kill = 1'b0; mid(); lit("kill_rdy", {63'd0, rdy}, 64'd1); lit("kill_oval", {63'd0, oval}, 64'd0);
    repeat (5) tick();

    // Kill during DONE does not cancel the strobe
    drive(6'd0, 7'h0B, 64'd7, 64'd6); tick(); val = 1'b0; repeat (4) tick();
    kill = 1'b1; mid(); lit("kill_done_oval", {63'd0, oval}, 64'd1); lit("kill_done_out", out, 64'd42); tick();
    kill = 1'b0; tick();

    // Kill alongside an ALU accept
    drive(6'd0, 7'h17, 64'd2, 64'd3); kill = 1'b1; tick(); val = 1'b0; kill = 1'b0;
    mid(); lit("kill_alu_out", out, 64'd5); tick();

    // Reset mid-multiply
    drive(6'd0, 7'h0F, ONES, ONES); tick(); val = 1'b0; tick(); tick();
    rst = 1'b1; mid();
    lit("midrst_oval", {63'd0, oval}, 64'd0); lit("midrst_out", out, 64'd0); lit("midrst_rdy", {63'd0, rdy}, 64'd0);
    tick();
    rst = 1'b0; mid(); lit("midrst_rdy_back", {63'd0, rdy}, 64'd1);
    repeat (6) tick();
    drive(6'd0, 7'h17, 64'd10, 64'd20); tick(); val = 1'b0;
    mid(); lit("after_rst_add", out, 64'd30); tick();

    // Unsupported requests
    drive(6'b000001, 7'h17, 64'd1, 64'd2); tick(); val = 1'b0;
    mid(); lit("fn01_oval", {63'd0, oval}, 64'd0); lit("fn01_rdy", {63'd0, rdy}, 64'd1); tick();
    drive(6'd0, 7'h11, 64'd1, 64'd2); tick(); val = 1'b0;
    mid(); lit("op0001_oval", {63'd0, oval}, 64'd0); tick();

    // ALU-only build: multiply unsupported, ALU still works
    fn = 6'd0; imm = 7'h0B; in1 = 64'd3; in2 = 64'd5; val2 = 1'b1; tick(); val2 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      mid();
      lit($sformatf("v10_mul_oval_t%0d", i), {63'd0, oval2}, 64'd0);
      lit($sformatf("v10_mul_rdy_t%0d", i), {63'd0, rdy2}, 64'd1);
      tick();
    end
    imm = 7'h17; in1 = 64'd2; in2 = 64'd3; val2 = 1'b1; tick(); val2 = 1'b0;
    mid(); lit("v10_add_oval", {63'd0, oval2}, 64'd1); lit("v10_add_out", out2, 64'd5); tick();

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
